// File: rtl/pipeline_interlock_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipe_ctrl_pkg                                              |
// | Brief   : State encodings and writer-compare helper for the interlock |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] reg_idx;
        logic       wr_en;
    } writer_t;

    function automatic logic writer_hits(input writer_t w, input logic [4:0] r);
        return w.wr_en && (w.reg_idx == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_interlock_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipeline_interlock_ctrl_if                                 |
// | Brief   : Pipeline-to-sequencer signal bundle (hazard inputs, enables)|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface pipeline_interlock_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ex_wr_reg;
    logic             ex_wr_en;
    logic [4:0]       mem_wr_reg;
    logic             mem_wr_en;
    logic [4:0]       wb_wr_reg;
    logic             wb_wr_en;
    logic             jump_id;
    logic             mem_busy;
    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;

    // master: the datapath side; slave: the sequencer
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en,
        output jump_id, mem_busy,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
        input  ex_mem_enable, mem_wb_enable, state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en,
        input  jump_id, mem_busy,
        output pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
        output ex_mem_enable, mem_wb_enable, state, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_interlock_ctrl_hazard_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_match                                               |
// | Brief   : Compares one ID source register against the in-flight writers|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  wire logic [4:0] i_src_reg,
    input  wire logic       i_src_used,
    input  wire writer_t    i_ex,
    input  wire writer_t    i_mem,
    input  wire writer_t    i_wb,
    output logic            o_hit
);

    logic w_match;

    // A write-first regfile already forwards the WB value, so WB only matters without bypass
    assign w_match = writer_hits(i_ex, i_src_reg)
                   | writer_hits(i_mem, i_src_reg)
                   | (!WB_BYPASS & writer_hits(i_wb, i_src_reg));

    assign o_hit = i_src_used & (i_src_reg != REG_ZERO) & w_match;

endmodule
`default_nettype wire

// File: rtl/pipeline_interlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipeline_interlock_ctrl                                    |
// | Brief   : 5-stage pipe sequencer: enables, RAW stall, jump squash,    |
// |           memory-busy freeze with timeout                            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pipeline_interlock_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYC  = 4,
    parameter int HOLD_MAX  = 16,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    pipeline_interlock_ctrl_if.slave bus
);

    localparam int c_INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int c_HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(HOLD_MAX);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    logic [1:0]          r_state;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0]    r_stall_count;

    logic [1:0]          w_next_state;
    logic [c_INIT_W-1:0] w_next_init;
    logic [c_HOLD_W-1:0] w_next_hold;
    logic                w_stall_inc;
    logic                w_pc_en;
    logic                w_if_id_en;
    logic                w_flush;
    logic                w_bubble;
    logic                w_ex_mem_en;
    logic                w_mem_wb_en;
    logic                w_raw;

    writer_t             w_ex;
    writer_t             w_mem;
    writer_t             w_wb;
    logic [4:0]          w_src [2];
    logic [1:0]          w_use;
    logic [1:0]          w_hit;

    assign w_ex  = {bus.ex_wr_reg,  bus.ex_wr_en};
    assign w_mem = {bus.mem_wr_reg, bus.mem_wr_en};
    assign w_wb  = {bus.wb_wr_reg,  bus.wb_wr_en};

    assign w_src[0] = bus.id_rs;
    assign w_src[1] = bus.id_rt;
    assign w_use    = {bus.id_uses_rt, bus.id_uses_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_match
            hazard_match #(
                .WB_BYPASS (WB_BYPASS)
            ) u_match (
                .i_src_reg  (w_src[gi]),
                .i_src_used (w_use[gi]),
                .i_ex       (w_ex),
                .i_mem      (w_mem),
                .i_wb       (w_wb),
                .o_hit      (w_hit[gi])
            );
        end
    endgenerate

    assign w_raw = |w_hit;

    always_comb begin
        w_next_state = r_state;
        w_next_init  = r_init_cnt;
        w_next_hold  = r_hold_cnt;
        w_stall_inc  = 1'b0;
        w_pc_en      = 1'b0;
        w_if_id_en   = 1'b0;
        w_flush      = 1'b0;
        w_bubble     = 1'b0;
        w_ex_mem_en  = 1'b0;
        w_mem_wb_en  = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_next_state = ST_RUN;
                    w_next_init  = '0;
                end else begin
                    w_next_init  = r_init_cnt + 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (bus.mem_busy && (r_state == ST_HOLD)) begin
                    if (r_hold_cnt == c_HOLD_MAX) begin
                        w_next_state = ST_ERR;
                    end else begin
                        w_next_hold  = r_hold_cnt + 1'b1;
                    end
                end else if (bus.mem_busy) begin
                    w_next_state = ST_HOLD;
                    w_next_hold  = c_HOLD_ONE;
                end else begin
                    // HOLD with memory ready is handled exactly like RUN in the same cycle
                    w_next_state = ST_RUN;
                    w_ex_mem_en  = 1'b1;
                    w_mem_wb_en  = 1'b1;
                    if (w_raw) begin
                        w_bubble    = 1'b1;
                        w_stall_inc = 1'b1;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_if_id_en = 1'b1;
                        w_flush    = bus.jump_id;
                    end
                end
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_init_cnt <= w_next_init;
            r_hold_cnt <= w_next_hold;
            if (w_stall_inc && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.pc_enable     = w_pc_en;
    assign bus.if_id_enable  = w_if_id_en;
    assign bus.if_id_flush   = w_flush;
    assign bus.id_ex_bubble  = w_bubble;
    assign bus.ex_mem_enable = w_ex_mem_en;
    assign bus.mem_wb_enable = w_mem_wb_en;
    assign bus.state         = r_state;
    assign bus.stall_count   = r_stall_count;

endmodule
`default_nettype wire
